rvfi_exit_monitor: RTL and testbench

RVFI_EXIT_MONITOR -- requirements
Module: rvfi_exit_monitor

---
 rtl/rvfi_exit_monitor.sv | 192 +++++++++++++++++++
 tb/tb_rvfi_exit_monitor.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_exit_monitor.sv
// Exit monitor for an RVFI-instrumented core. It watches the commit ports for the
// tohost exit store and reports pass/fail/timeout/hang together with run counters.

package riscv;
  localparam int XLEN = 64;
endpackage

package rvfi_pkg;
  typedef struct packed {
    logic                     valid;
    logic [63:0]              order;
    logic [31:0]              insn;
    logic                     trap;
    logic                     halt;
    logic                     intr;
    logic [1:0]               mode;
    logic [riscv::XLEN-1:0]   pc_rdata;
    logic [riscv::XLEN-1:0]   pc_wdata;
    logic [riscv::XLEN-1:0]   mem_addr;
    logic [riscv::XLEN/8-1:0] mem_rmask;
    logic [riscv::XLEN/8-1:0] mem_wmask;
    logic [63:0]              mem_rdata;
    logic [63:0]              mem_wdata;
  } rvfi_instr_t;
endpackage

module rvfi_exit_monitor #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int CNT_W           = 64,
  parameter int HANG_LIMIT      = 10000
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
  input  logic [riscv::XLEN-1:0]                    tohost_addr_i,
  input  logic [CNT_W-1:0]                          timeout_i,
  output logic [1:0]                                state_o,
  output logic [2:0]                                status_o,
  output logic [62:0]                               exit_code_o,
  output logic                                      done_o,
  output logic [CNT_W-1:0]                          cycle_o,
  output logic [CNT_W-1:0]                          instret_o,
  output logic [CNT_W-1:0]                          trap_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] ST_NONE    = 3'd0;
  localparam logic [2:0] ST_PASS    = 3'd1;
  localparam logic [2:0] ST_FAIL    = 3'd2;
  localparam logic [2:0] ST_TIMEOUT = 3'd3;
  localparam logic [2:0] ST_HANG    = 3'd4;

  localparam int IDLE_W = (HANG_LIMIT > 1) ? $clog2(HANG_LIMIT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_ONE  = 1;
  localparam logic [IDLE_W-1:0] HANG_LAST = (HANG_LIMIT == 0) ? '0 : IDLE_W'(HANG_LIMIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = 1;

  state_e            state_q;
  logic [2:0]        status_q;
  logic [62:0]       exit_q;
  logic              done_q;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [CNT_W-1:0]  trap_q, trap_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic [NR_COMMIT_PORTS-1:0] port_hit;
  logic [NR_COMMIT_PORTS-1:0] unused_port;
  logic                       unused_misc;
  logic                       hit_found;
  logic [62:0]                hit_code;
  logic [3:0]                 n_valid;
  logic [3:0]                 n_trap;
  logic                       in_run;
  logic                       timeout_fire;
  logic                       hang_fire;

  // Detection looks only at the data side of the commit, so any store width or
  // encoding that writes the tohost doubleword is recognised.
  for (genvar g = 0; g < NR_COMMIT_PORTS; g++) begin : g_port
    assign port_hit[g] = rvfi_i[g].valid
                      && (rvfi_i[g].mem_wmask != '0)
                      && (rvfi_i[g].mem_addr[riscv::XLEN-1:3] == tohost_addr_i[riscv::XLEN-1:3])
                      && rvfi_i[g].mem_wdata[0]
                      && (rvfi_i[g].mem_wdata[63:48] == 16'h0);
    assign unused_port[g] = ^{rvfi_i[g].order, rvfi_i[g].insn, rvfi_i[g].halt,
                              rvfi_i[g].intr, rvfi_i[g].mode, rvfi_i[g].pc_rdata,
                              rvfi_i[g].pc_wdata, rvfi_i[g].mem_rmask,
                              rvfi_i[g].mem_rdata, rvfi_i[g].mem_addr[2:0]};
  end
  assign unused_misc = ^{unused_port, tohost_addr_i[2:0]};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
    sat_add = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Lowest-index hitting port supplies the exit code.
  always_comb begin
    hit_found = 1'b0;
    hit_code  = '0;
    n_valid   = '0;
    n_trap    = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (rvfi_i[i].valid) n_valid = n_valid + 4'd1;
      if (rvfi_i[i].trap && !rvfi_i[i].valid) n_trap = n_trap + 4'd1;
      if (!hit_found && port_hit[i]) begin
        hit_found = 1'b1;
        hit_code  = rvfi_i[i].mem_wdata[63:1];
      end
    end
  end

  always_comb begin
    cycle_d   = (&cycle_q) ? cycle_q : cycle_q + CNT_ONE;
    instret_d = sat_add(instret_q, n_valid);
    trap_d    = sat_add(trap_q, n_trap);
    if (HANG_LIMIT == 0 || n_valid != 4'd0) idle_d = '0;
    else                                    idle_d = idle_q + IDLE_ONE;
  end

  assign in_run       = (state_q == S_RUN);
  assign timeout_fire = (timeout_i != '0) && (cycle_q >= timeout_i);
  assign hang_fire    = (HANG_LIMIT != 0) && in_run && (n_valid == 4'd0) && (idle_q == HANG_LAST);

  // The terminating cycle's commits are still counted, but the cycle counter
  // freezes on the edge that enters DONE so a timeout reads back as the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      status_q  <= ST_NONE;
      exit_q    <= '0;
      done_q    <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
      trap_q    <= '0;
      idle_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RUN: begin
          if (in_run) begin
            instret_q <= instret_d;
            trap_q    <= trap_d;
          end
          if (in_run && hit_found) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            exit_q   <= hit_code;
            status_q <= (hit_code == '0) ? ST_PASS : ST_FAIL;
          end else if (timeout_fire) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            exit_q   <= '0;
            status_q <= ST_TIMEOUT;
          end else if (hang_fire) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            exit_q   <= '0;
            status_q <= ST_HANG;
          end else begin
            cycle_q <= cycle_d;
            if (in_run) begin
              idle_q <= idle_d;
            end else if (tohost_addr_i != '0) begin
              state_q <= S_RUN;
            end
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign state_o     = state_q;
  assign status_o    = status_q;
  assign exit_code_o = exit_q;
  assign done_o      = done_q;
  assign cycle_o     = cycle_q;
  assign instret_o   = instret_q;
  assign trap_cnt_o  = trap_q;

endmodule

// File: tb/tb_rvfi_exit_monitor.sv
// Bench for rvfi_exit_monitor: directed exit scenarios plus randomized runs scored
// against a behavioural model, and a narrow-counter instance for saturation.

module tb_rvfi_exit_monitor;

  localparam int NP    = 2;
  localparam int HANG  = 16;
  localparam int EXP_W = 3 + 63 + 64 * 3;

  logic clk;
  logic rst_s;
  rvfi_pkg::rvfi_instr_t [NP-1:0] rvfi_s;
  logic [63:0] tohost_s;
  logic [63:0] timeout_s;
  logic [3:0]  timeout_b;

  logic [1:0]  state_a, state_b;
  logic [2:0]  status_a, status_b;
  logic [62:0] exit_a, exit_b;
  logic        done_a, done_b;
  logic [63:0] cycle_a, instret_a, trap_a;
  logic [3:0]  cycle_b, instret_b, trap_b;

  int tests = 0;
  int fails = 0;

  logic [EXP_W-1:0] exp_q[$];

  // model state: 0 idle, 1 run, 2 done
  int          m_state;
  logic [63:0] m_cycle, m_instret, m_trap;
  int          m_idle;
  logic [62:0] m_exit;
  logic [2:0]  m_status;
  bit          m_done;

  rvfi_exit_monitor #(.NR_COMMIT_PORTS(NP), .CNT_W(64), .HANG_LIMIT(HANG)) dut_a (
    .clk_i(clk), .rst_i(rst_s), .rvfi_i(rvfi_s), .tohost_addr_i(tohost_s),
    .timeout_i(timeout_s), .state_o(state_a), .status_o(status_a),
    .exit_code_o(exit_a), .done_o(done_a), .cycle_o(cycle_a),
    .instret_o(instret_a), .trap_cnt_o(trap_a)
  );

  rvfi_exit_monitor #(.NR_COMMIT_PORTS(NP), .CNT_W(4), .HANG_LIMIT(0)) dut_b (
    .clk_i(clk), .rst_i(rst_s), .rvfi_i(rvfi_s), .tohost_addr_i(tohost_s),
    .timeout_i(timeout_b), .state_o(state_b), .status_o(status_b),
    .exit_code_o(exit_b), .done_o(done_b), .cycle_o(cycle_b),
    .instret_o(instret_b), .trap_cnt_o(trap_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model
  function automatic logic [63:0] sat64(input logic [63:0] a, input int n);
    if (a > 64'hFFFF_FFFF_FFFF_FFFF - 64'(n)) return 64'hFFFF_FFFF_FFFF_FFFF;
    return a + 64'(n);
  endfunction

  function automatic bit is_exit_store(input rvfi_pkg::rvfi_instr_t r, input logic [63:0] th);
    return r.valid && (r.mem_wmask != 8'h0) && (r.mem_addr[63:3] == th[63:3])
        && r.mem_wdata[0] && (r.mem_wdata[63:48] == 16'h0);
  endfunction

  task automatic model_finish(input logic [2:0] st, input logic [62:0] code);
    m_state  = 2;
    m_status = st;
    m_exit   = code;
    m_done   = 1'b1;
    exp_q.push_back({st, code, m_cycle, m_instret, m_trap});
  endtask

  task automatic model_step();
    int nv, nt, hit;
    m_done = 1'b0;
    if (rst_s) begin
      m_state = 0; m_cycle = 0; m_instret = 0; m_trap = 0;
      m_idle = 0; m_exit = 0; m_status = 0;
      return;
    end
    if (m_state == 2) return;
    nv = 0; nt = 0; hit = -1;
    for (int p = 0; p < NP; p++) begin
      if (rvfi_s[p].valid) nv++;
      if (rvfi_s[p].trap && !rvfi_s[p].valid) nt++;
      if (hit < 0 && is_exit_store(rvfi_s[p], tohost_s)) hit = p;
    end
    if (m_state == 1) begin
      m_instret = sat64(m_instret, nv);
      m_trap    = sat64(m_trap, nt);
    end
    if (m_state == 1 && hit >= 0) begin
      if (rvfi_s[hit].mem_wdata[63:1] == 63'h0) model_finish(3'd1, 63'h0);
      else model_finish(3'd2, rvfi_s[hit].mem_wdata[63:1]);
    end else if (timeout_s != 0 && m_cycle >= timeout_s) begin
      model_finish(3'd3, 63'h0);
    end else if (m_state == 1 && nv == 0 && m_idle + 1 >= HANG) begin
      model_finish(3'd4, 63'h0);
    end else begin
      m_cycle = sat64(m_cycle, 1);
      if (m_state == 1) m_idle = (nv != 0) ? 0 : m_idle + 1;
      else if (tohost_s != 0) m_state = 1;
    end
  endtask

  // driver tasks
  task automatic check_cycle();
    check("state", 64'(state_a), 64'(m_state));
    check("done_pulse", 64'(done_a), 64'(m_done));
    check("status", 64'(status_a), 64'(m_status));
    check("exit_code", 64'(exit_a), 64'(m_exit));
    check("cycle", cycle_a, m_cycle);
    check("instret", instret_a, m_instret);
    check("trap_cnt", trap_a, m_trap);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic do_reset();
    rst_s  = 1'b1;
    rvfi_s = '0;
    step();
    step();
    rst_s = 1'b0;
  endtask

  task automatic set_store(input int p, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] mask);
    rvfi_s[p].valid     = 1'b1;
    rvfi_s[p].mem_addr  = addr;
    rvfi_s[p].mem_wdata = wdata;
    rvfi_s[p].mem_wmask = mask;
  endtask

  task automatic run_until_done(input int cap);
    int left;
    left = cap;
    rvfi_s = '0;
    while (m_state != 2 && left > 0) begin
      step();
      left--;
    end
    check("reached_done", 64'(m_state == 2), 64'd1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (done_a === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_done: got status %0d expected no exit", status_a);
      end else begin
        e = exp_q.pop_front();
        check("sb_status", 64'(status_a), 64'(e[EXP_W-1 -: 3]));
        check("sb_exit", 64'(exit_a), 64'(e[EXP_W-4 -: 63]));
        check("sb_cycle", cycle_a, e[191:128]);
        check("sb_instret", instret_a, e[127:64]);
        check("sb_trap", trap_a, e[63:0]);
      end
    end
  end

  // stimulus
  initial begin
    logic [63:0] wd;
    int pv, lim;
    rst_s = 1'b1; rvfi_s = '0; tohost_s = '0; timeout_s = '0; timeout_b = '0;
    m_state = 0; m_cycle = 0; m_instret = 0; m_trap = 0; m_idle = 0;
    m_exit = 0; m_status = 0; m_done = 0;

    // reset values
    do_reset();

    // single PASS on port 1, then hits while in DONE
    tohost_s = 64'h8000_1000;
    step();
    for (int i = 0; i < 3; i++) begin rvfi_s = '0; rvfi_s[0].valid = 1'b1; step(); end
    rvfi_s = '0;
    set_store(1, 64'h8000_1000, 64'h1, 8'hFF);
    step();
    rvfi_s = '0;
    step();
    set_store(0, 64'h8000_1000, 64'h7, 8'hFF);
    step();
    step();

    // two hits in one cycle, port 0 wins
    do_reset();
    tohost_s = 64'h8000_1000;
    step();
    set_store(0, 64'h8000_1000, 64'h7, 8'hFF);
    set_store(1, 64'h8000_1000, 64'h1, 8'hFF);
    step();
    rvfi_s = '0;
    step();

    // timeout while tohost unknown
    do_reset();
    tohost_s = '0; timeout_s = 64'd50;
    run_until_done(60);
    step();

    // hang, with a commit at idle count 15 restarting the count
    do_reset();
    tohost_s = 64'h8000_1000; timeout_s = '0;
    step();
    for (int i = 0; i < 15; i++) step();
    rvfi_s[1].valid = 1'b1;
    step();
    run_until_done(20);
    step();

    // hit and timeout in the same cycle
    do_reset();
    timeout_s = 64'd10;
    for (int i = 0; i < 10; i++) step();
    set_store(0, 64'h8000_1000, 64'h5, 8'h01);
    step();
    rvfi_s = '0;
    step();

    // timeout and hang in the same cycle
    do_reset();
    timeout_s = 64'd16;
    run_until_done(30);

    // reset from DONE
    do_reset();

    // non-hitting stores, then a hit with ignored low address bits
    tohost_s = 64'h8000_2000; timeout_s = '0;
    step();
    set_store(0, 64'h8000_2000, 64'h2, 8'hFF); step();
    set_store(0, 64'h8000_2000, 64'h0001_0000_0000_0001, 8'hFF); step();
    set_store(0, 64'h8000_2000, 64'h1, 8'h00); step();
    set_store(0, 64'h8000_2008, 64'h1, 8'hFF); step();
    rvfi_s = '0; rvfi_s[1].trap = 1'b1; step();
    set_store(0, 64'h8000_2004, 64'h1, 8'hF0); step();
    rvfi_s = '0; step();

    // counter saturation on the narrow instance
    do_reset();
    tohost_s = 64'h1000; timeout_s = '0;
    step();
    for (int i = 0; i < 20; i++) begin
      rvfi_s = '0;
      rvfi_s[0].valid = 1'b1;
      rvfi_s[1].trap  = 1'b1;
      step();
      check("sat_instret", 64'(instret_b), (i + 1 > 15) ? 64'd15 : 64'(i + 1));
    end
    check("sat_trap", 64'(trap_b), 64'd15);
    check("sat_cycle", 64'(cycle_b), 64'd15);
    check("sat_state", 64'(state_b), 64'd1);

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      do_reset();
      timeout_s = 64'($urandom_range(20, 250));
      tohost_s  = '0;
      for (int i = 0; i < $urandom_range(0, 5); i++) step();
      tohost_s = {$urandom_range(1, 255), $urandom};
      pv  = (r % 4 == 0) ? 5 : 60;
      lim = (r % 6 == 5) ? $urandom_range(3, 15) : 300;
      for (int c = 0; c < lim && m_state != 2; c++) begin
        rvfi_s = '0;
        if ($urandom_range(0, 49) == 0) tohost_s = {$urandom_range(1, 255), $urandom};
        for (int p = 0; p < NP; p++) begin
          if ($urandom_range(0, 99) < pv) begin
            rvfi_s[p].valid = 1'b1;
            if (r % 3 != 2 && $urandom_range(0, 9) == 0) begin
              case ($urandom_range(0, 3))
                0:       wd = 64'h1;
                1:       wd = {16'h0, 16'($urandom), $urandom} | 64'h1;
                2:       wd = {$urandom, $urandom} & ~64'h1;
                default: wd = {16'($urandom_range(1, 65535)), 16'($urandom), $urandom} | 64'h1;
              endcase
              set_store(p,
                ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                            : {tohost_s[63:3], 3'($urandom_range(0, 7))},
                wd,
                ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
            end
          end else begin
            rvfi_s[p].trap = ($urandom_range(0, 3) == 0);
          end
        end
        step();
      end
      set_store(0, tohost_s, 64'h1, 8'hFF);
      step();
      step();
    end

    rvfi_s = '0;
    step();
    step();
    check("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
